// File: rtl/placar_pkg.sv
// Shared constants, converter state encoding and the double-dabble digit
// adjust used by the placar scoring stage.
package placar_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_DIGITS  = 5;
    localparam int BCD_W       = BCD_DIGIT_W * BCD_DIGITS;
    localparam int MAX_SCORE   = 99999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (v[d*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5) begin
                r[d*BCD_DIGIT_W +: BCD_DIGIT_W] = v[d*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
            end else begin
                r[d*BCD_DIGIT_W +: BCD_DIGIT_W] = v[d*BCD_DIGIT_W +: BCD_DIGIT_W];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, SCORE_W shifts per
// conversion, result loaded into bcd in the DONE state.
module bin2bcd_seq
    import placar_pkg::*;
#(
    parameter int SCORE_W = 17
) (
    input  logic               CLOCK_25,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    localparam int CNT_W = $clog2(SCORE_W + 1);

    conv_state_e        state_r;
    conv_state_e        state_nxt_s;
    logic [SCORE_W-1:0] bin_r;
    logic [BCD_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [BCD_W-1:0]   bcd_r;

    // Converter state register.
    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_W'(SCORE_W - 1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Shift datapath and result register.
    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            bin_r <= '0;
            acc_r <= '0;
            cnt_r <= '0;
            bcd_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        bin_r <= bin;
                        acc_r <= '0;
                        cnt_r <= '0;
                    end
                end
                ST_SHIFT: begin
                    {acc_r, bin_r} <= {bcd_adjust(acc_r), bin_r} << 1;
                    cnt_r          <= cnt_r + CNT_W'(1);
                end
                ST_DONE: bcd_r <= acc_r;
                default: bcd_r <= bcd_r;
            endcase
        end
    end

    assign busy = (state_r != ST_IDLE);
    assign done = (state_r == ST_DONE);
    assign bcd  = bcd_r;

endmodule

// File: rtl/placar_score_ctrl.sv
// Placar scoring stage: lane edge detect, saturating score/combo with combo
// multiplier, and a background BCD conversion feeding the 7-segment driver.
module placar_score_ctrl
    import placar_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int SCORE_W    = 17,
    parameter int MAX_SCORE  = placar_pkg::MAX_SCORE,
    parameter int COMBO_STEP = 10,
    parameter int MAX_MULT   = 4
) (
    input  logic               CLOCK_25,
    input  logic               rst,
    input  logic [LANES-1:0]   ponto_vec,
    input  logic [LANES-1:0]   erro_vec,
    input  logic               fim_de_jogo,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         combo,
    output logic [2:0]         mult,
    output logic [19:0]        display,
    output logic               display_valid
);

    localparam int HIT_W = $clog2(LANES + 1);
    localparam int SUM_W = SCORE_W + 4;

    logic [LANES-1:0]   prev_ponto_r, prev_erro_r;
    logic [HIT_W-1:0]   hits_s, hits_r;
    logic               miss_s, miss_r;
    logic [SCORE_W-1:0] score_r, score_nxt_s, conv_val_r;
    logic [7:0]         combo_r, combo_nxt_s, quot_s;
    logic [8:0]         combo_sum_s;
    logic [2:0]         mult_r, mult_nxt_s;
    logic [SUM_W-1:0]   sum_s;
    logic               score_chg_r, pending_r, display_valid_r;
    logic               start_s, conv_busy_s, conv_done_s;

    // Rising-edge detect and hit popcount.
    always_comb begin
        hits_s = '0;
        for (int i = 0; i < LANES; i++) begin
            hits_s = hits_s + HIT_W'(ponto_vec[i] & ~prev_ponto_r[i]);
        end
        miss_s = |(erro_vec & ~prev_erro_r);
    end

    // Next score, combo and multiplier; a miss still scores at the old multiplier.
    always_comb begin
        sum_s       = SUM_W'(score_r) + SUM_W'(hits_r) * SUM_W'(mult_r);
        combo_sum_s = 9'(combo_r) + 9'(hits_r);
        if (fim_de_jogo) begin
            score_nxt_s = score_r;
            combo_nxt_s = combo_r;
        end else begin
            if (sum_s > SUM_W'(MAX_SCORE)) begin
                score_nxt_s = SCORE_W'(MAX_SCORE);
            end else begin
                score_nxt_s = sum_s[SCORE_W-1:0];
            end
            if (miss_r) begin
                combo_nxt_s = 8'd0;
            end else if (combo_sum_s > 9'd255) begin
                combo_nxt_s = 8'd255;
            end else begin
                combo_nxt_s = combo_sum_s[7:0];
            end
        end
        quot_s = combo_nxt_s / 8'(COMBO_STEP);
        if (quot_s >= 8'(MAX_MULT - 1)) begin
            mult_nxt_s = 3'(MAX_MULT);
        end else begin
            mult_nxt_s = quot_s[2:0] + 3'd1;
        end
    end

    assign start_s = (score_chg_r | pending_r) & ~conv_busy_s;

    // Pipeline, score state, pending restart and display_valid tracking.
    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            prev_ponto_r    <= '1;
            prev_erro_r     <= '1;
            hits_r          <= '0;
            miss_r          <= 1'b0;
            score_r         <= '0;
            combo_r         <= 8'd0;
            mult_r          <= 3'd1;
            score_chg_r     <= 1'b0;
            pending_r       <= 1'b0;
            conv_val_r      <= '0;
            display_valid_r <= 1'b1;
        end else begin
            prev_ponto_r <= ponto_vec;
            prev_erro_r  <= erro_vec;
            hits_r       <= hits_s;
            miss_r       <= miss_s;
            score_r      <= score_nxt_s;
            combo_r      <= combo_nxt_s;
            mult_r       <= mult_nxt_s;
            score_chg_r  <= (score_nxt_s != score_r);
            if (start_s) begin
                pending_r  <= 1'b0;
                conv_val_r <= score_r;
            end else if (score_chg_r && conv_busy_s) begin
                pending_r <= 1'b1;
            end
            // A conversion that finishes on a stale value keeps valid low.
            if (score_chg_r) begin
                display_valid_r <= 1'b0;
            end else if (conv_done_s) begin
                display_valid_r <= (conv_val_r == score_r);
            end
        end
    end

    bin2bcd_seq #(
        .SCORE_W (SCORE_W)
    ) u_bin2bcd (
        .CLOCK_25 (CLOCK_25),
        .rst      (rst),
        .start    (start_s),
        .bin      (score_r),
        .busy     (conv_busy_s),
        .done     (conv_done_s),
        .bcd      (display)
    );

    assign score         = score_r;
    assign combo         = combo_r;
    assign mult          = mult_r;
    assign display_valid = display_valid_r;

endmodule

// File: tb/tb_placar_score_ctrl.sv
// Directed self-checking bench for placar_score_ctrl.
module tb_placar_score_ctrl;

    logic        CLOCK_25 = 1'b0;
    logic        rst;
    logic [7:0]  ponto_vec;
    logic [7:0]  erro_vec;
    logic        fim_de_jogo;
    logic [16:0] score;
    logic [7:0]  combo;
    logic [2:0]  mult;
    logic [19:0] display;
    logic        display_valid;

    int n_checks = 0;
    int n_fail   = 0;

    placar_score_ctrl dut (
        .CLOCK_25      (CLOCK_25),
        .rst           (rst),
        .ponto_vec     (ponto_vec),
        .erro_vec      (erro_vec),
        .fim_de_jogo   (fim_de_jogo),
        .score         (score),
        .combo         (combo),
        .mult          (mult),
        .display       (display),
        .display_valid (display_valid)
    );

    always #5 CLOCK_25 = ~CLOCK_25;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_25);
        #1;
    endtask

    // One-cycle level pulse; the score register has updated when this returns.
    task automatic pulse(input logic [7:0] hit, input logic [7:0] miss);
        ponto_vec = hit;
        erro_vec  = miss;
        tick();
        ponto_vec = 8'h00;
        erro_vec  = 8'h00;
        tick();
    endtask

    task automatic wait_valid(output int n);
        n = 2;
        tick();
        tick();
        while (!display_valid && n < 100) begin
            tick();
            n++;
        end
        check_val("wait_valid", 32'(display_valid), 32'd1);
    endtask

    int n_wait;
    int ms, mc, mm;

    initial begin
        rst         = 1'b1;
        ponto_vec   = 8'h01;
        erro_vec    = 8'h00;
        fim_de_jogo = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        check_val("rst_score", 32'(score), 32'd0);
        check_val("rst_combo", 32'(combo), 32'd0);
        check_val("rst_mult", 32'(mult), 32'd1);
        check_val("rst_display", 32'(display), 32'h00000);
        check_val("rst_valid", 32'(display_valid), 32'd1);
        ponto_vec = 8'h00;
        repeat (2) tick();
        check_val("held_lane_ignored", 32'(score), 32'd0);

        repeat (9) pulse(8'h01, 8'h00);
        check_val("pulses_score", 32'(score), 32'd9);
        check_val("pulses_combo", 32'(combo), 32'd9);
        check_val("pulses_mult", 32'(mult), 32'd1);
        wait_valid(n_wait);
        check_val("pulses_display", 32'(display), 32'h00009);

        pulse(8'hFF, 8'h00);
        check_val("all_lanes_score", 32'(score), 32'd17);
        check_val("all_lanes_combo", 32'(combo), 32'd17);
        check_val("all_lanes_mult", 32'(mult), 32'd2);
        pulse(8'h01, 8'h00);
        check_val("mult2_score", 32'(score), 32'd19);
        check_val("mult2_combo", 32'(combo), 32'd18);

        ponto_vec = 8'h01;
        repeat (50) tick();
        ponto_vec = 8'h00;
        tick();
        check_val("long_level_score", 32'(score), 32'd21);
        check_val("long_level_combo", 32'(combo), 32'd19);

        pulse(8'h02, 8'h04);
        check_val("hit_miss_score", 32'(score), 32'd23);
        check_val("hit_miss_combo", 32'(combo), 32'd0);
        check_val("hit_miss_mult", 32'(mult), 32'd1);
        wait_valid(n_wait);
        check_val("hit_miss_display", 32'(display), 32'h00023);

        // Second change lands 6 cycles into the first conversion.
        pulse(8'h01, 8'h00);
        repeat (5) tick();
        pulse(8'h01, 8'h00);
        check_val("coll_score", 32'(score), 32'd25);
        check_val("coll_combo", 32'(combo), 32'd2);
        check_val("coll_valid_low", 32'(display_valid), 32'd0);
        repeat (14) tick();
        check_val("coll_stale_display", 32'(display), 32'h00024);
        check_val("coll_stale_valid", 32'(display_valid), 32'd0);
        wait_valid(n_wait);
        check_val("coll_display", 32'(display), 32'h00025);
        check_val("coll_latency", 32'(n_wait), 32'd17);

        fim_de_jogo = 1'b1;
        pulse(8'hFF, 8'h00);
        pulse(8'h01, 8'h00);
        check_val("freeze_score", 32'(score), 32'd25);
        check_val("freeze_combo", 32'(combo), 32'd2);
        fim_de_jogo = 1'b0;
        tick();
        pulse(8'h01, 8'h00);
        check_val("unfreeze_score", 32'(score), 32'd26);
        check_val("unfreeze_combo", 32'(combo), 32'd3);

        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_val("rst_shift_score", 32'(score), 32'd0);
        check_val("rst_shift_combo", 32'(combo), 32'd0);
        check_val("rst_shift_mult", 32'(mult), 32'd1);
        check_val("rst_shift_display", 32'(display), 32'h00000);
        check_val("rst_shift_valid", 32'(display_valid), 32'd1);
        rst = 1'b0;
        tick();

        repeat (5) pulse(8'hFF, 8'h00);
        check_val("ramp_score", 32'(score), 32'd88);
        check_val("ramp_mult", 32'(mult), 32'd4);
        ms = 88;
        mc = 40;
        mm = 4;
        while (ms < 99999) begin
            pulse(8'hFF, 8'h00);
            ms = ms + 8 * mm;
            if (ms > 99999) ms = 99999;
            mc = (mc + 8 > 255) ? 255 : mc + 8;
            mm = (1 + mc / 10 > 4) ? 4 : 1 + mc / 10;
        end
        check_val("sat_score", 32'(score), 32'd99999);
        check_val("sat_combo", 32'(combo), 32'd255);
        check_val("sat_mult", 32'(mult), 32'd4);
        pulse(8'hFF, 8'h00);
        check_val("sat_hold", 32'(score), 32'd99999);
        wait_valid(n_wait);
        check_val("sat_display", 32'(display), 32'h99999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
